// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types and constants for the SOPC instruction/data memory arbiter.
// Imported by the arbiter, its priority sub-block and the bus interface.
package sopc_mem_arbiter_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned SEL_W        = 4;
    localparam int unsigned WAIT_CNT_W   = 3;
    localparam int unsigned STARVE_CNT_W = 4;

    localparam int unsigned WAIT_CYCLES_DEF  = 1;
    localparam int unsigned STARVE_LIMIT_DEF = 3;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [SEL_W-1:0] SEL_ALL = SEL_W'(4'hF);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_INST,
        GNT_DATA
    } grant_t;

    // One memory command as presented on the shared memory port.
    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// CPU fetch port, CPU load/store port and shared memory port of the arbiter.
// slave = arbiter view, master = CPU + memory view.
interface sopc_mem_arbiter_if;
    import sopc_mem_arbiter_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_ack;

    logic              data_req;
    logic              data_we;
    logic [SEL_W-1:0]  data_sel;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_ack;

    logic              mem_ce;
    logic              mem_we;
    logic [SEL_W-1:0]  mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_req;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_sel, data_addr, data_wdata,
        input  mem_rdata,
        output inst_rdata, inst_ack,
        output data_rdata, data_ack,
        output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        output stall_req
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_sel, data_addr, data_wdata,
        output mem_rdata,
        input  inst_rdata, inst_ack,
        input  data_rdata, data_ack,
        input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        input  stall_req
    );

endinterface

// File: rtl/sopc_mem_arbiter_prio.sv
// Grant decision: data port wins unless fetch has been passed over
// STARVE_LIMIT times in a row while it was waiting.
module sopc_arb_prio
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                    inst_req,
    input  logic                    data_req,
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
    output logic                    gnt_valid_c,
    output grant_t                  gnt_c
);

    logic starved_c;

    assign starved_c = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

    always_comb begin
        gnt_valid_c = inst_req | data_req;
        gnt_c       = GNT_DATA;
        if (inst_req && (!data_req || starved_c)) begin
            gnt_c = GNT_INST;
        end
    end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Shares one single-port synchronous RAM between CPU fetch and load/store,
// with wait-state insertion and a combinational stall request to the pipeline.
module sopc_mem_arbiter
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES  = WAIT_CYCLES_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sopc_mem_arbiter_if.slave bus
);

    arb_state_t              state_q, state_d;
    grant_t                  grant_q, grant_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    mem_ce_q, mem_ce_d;
    logic                    inst_ack_q, inst_ack_d;
    logic                    data_ack_q, data_ack_d;
    logic [DATA_W-1:0]       inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]       data_rdata_q, data_rdata_d;

    logic     gnt_valid_c;
    grant_t   gnt_c;
    mem_cmd_t inst_cmd_c;
    mem_cmd_t data_cmd_c;
    mem_cmd_t mem_cmd_c;

    sopc_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .inst_req    (bus.inst_req),
        .data_req    (bus.data_req),
        .starve_cnt  (starve_cnt_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_c       (gnt_c)
    );

    // Arbitration, wait-state counting and response capture.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_ce_d     = CHIP_DISABLE;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    state_d    = ACCESS;
                    grant_d    = gnt_c;
                    wait_cnt_d = '0;
                    mem_ce_d   = CHIP_ENABLE;
                    if (gnt_c == GNT_INST) begin
                        starve_cnt_d = '0;
                    end else if (bus.inst_req &&
                                 (starve_cnt_q != STARVE_CNT_W'(STARVE_LIMIT))) begin
                        starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt_q == WAIT_CNT_W'(WAIT_CYCLES)) begin
                    state_d = RESP;
                    if (grant_q == GNT_INST) begin
                        inst_ack_d   = 1'b1;
                        inst_rdata_d = bus.mem_rdata;
                    end else begin
                        data_ack_d   = 1'b1;
                        data_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                    mem_ce_d   = CHIP_ENABLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_INST;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            mem_ce_q     <= CHIP_DISABLE;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_ce_q     <= mem_ce_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Request fields are not latched: the granted port muxes straight through.
    always_comb begin
        inst_cmd_c      = '0;
        inst_cmd_c.we   = WRITE_DISABLE;
        inst_cmd_c.sel  = SEL_ALL;
        inst_cmd_c.addr = bus.inst_addr;

        data_cmd_c       = '0;
        data_cmd_c.we    = bus.data_we ? WRITE_ENABLE : WRITE_DISABLE;
        data_cmd_c.sel   = bus.data_sel;
        data_cmd_c.addr  = bus.data_addr;
        data_cmd_c.wdata = bus.data_wdata;

        mem_cmd_c = '0;
        if (mem_ce_q == CHIP_ENABLE) begin
            mem_cmd_c = (grant_q == GNT_INST) ? inst_cmd_c : data_cmd_c;
        end
    end

    assign bus.mem_ce     = mem_ce_q;
    assign bus.mem_we     = mem_cmd_c.we;
    assign bus.mem_sel    = mem_cmd_c.sel;
    assign bus.mem_addr   = mem_cmd_c.addr;
    assign bus.mem_wdata  = mem_cmd_c.wdata;

    assign bus.inst_ack   = inst_ack_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_ack   = data_ack_q;
    assign bus.data_rdata = data_rdata_q;

    // Held low during reset so every output reads zero while rst is asserted.
    assign bus.stall_req = (rst != RST_ENABLE) &
                           ((bus.inst_req & ~inst_ack_q) | (bus.data_req & ~data_ack_q));

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Scoreboard bench for sopc_mem_arbiter: WAIT_CYCLES=1 main instance plus a
// WAIT_CYCLES=0 instance, both sharing one behavioural RAM image.
module tb_sopc_mem_arbiter;
    import sopc_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_load;

    always #5 clk = ~clk;

    sopc_mem_arbiter_if bus ();
    sopc_mem_arbiter_if bus0 ();

    sopc_mem_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sopc_mem_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(3)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int data_ack_cnt = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_inst[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_inst0[$];
    byte         grant_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h3401_1100;
        return {8'hA5, 8'(i), ~8'(i), 8'h5A};
    endfunction

    // Behavioural synchronous RAM: read data visible while mem_ce is high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.mem_ce && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_sel[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    assign bus.mem_rdata  = bus.mem_ce  ? mem[bus.mem_addr[9:2]]  : 32'h0;
    assign bus0.mem_rdata = bus0.mem_ce ? mem[bus0.mem_addr[9:2]] : 32'h0;

    // Scoreboard: every ack pops the oldest expected word of its port.
    always @(negedge clk) begin
        if (bus.inst_ack) begin
            grant_log.push_back("I");
            if (exp_inst.size() == 0) check("inst_ack_spurious", 32'(bus.inst_ack), 32'd0);
            else check("inst_rdata", bus.inst_rdata, exp_inst.pop_front());
        end
        if (bus.data_ack) begin
            grant_log.push_back("D");
            data_ack_cnt <= data_ack_cnt + 1;
            if (exp_data.size() == 0) check("data_ack_spurious", 32'(bus.data_ack), 32'd0);
            else check("data_rdata", bus.data_rdata, exp_data.pop_front());
        end
        if (bus0.inst_ack) begin
            if (exp_inst0.size() == 0) check("w0_inst_ack_spurious", 32'(bus0.inst_ack), 32'd0);
            else check("w0_inst_rdata", bus0.inst_rdata, exp_inst0.pop_front());
        end
        if (bus0.data_ack) check("w0_data_ack_spurious", 32'(bus0.data_ack), 32'd0);
    end

    // Requester protocol: fields stay put while a request is pending.
    logic        pi_pend, pd_pend;
    logic [31:0] pi_addr, pd_addr, pd_wdata;
    always @(negedge clk) begin
        if (rst && pi_pend && bus.inst_req && !bus.inst_ack)
            assert (bus.inst_addr == pi_addr) else $error("protocol: inst_addr changed mid-request");
        if (rst && pd_pend && bus.data_req && !bus.data_ack)
            assert (bus.data_addr == pd_addr && bus.data_wdata == pd_wdata)
                else $error("protocol: data fields changed mid-request");
        pi_pend  <= bus.inst_req && !bus.inst_ack;
        pd_pend  <= bus.data_req && !bus.data_ack;
        pi_addr  <= bus.inst_addr;
        pd_addr  <= bus.data_addr;
        pd_wdata <= bus.data_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_fetch(input logic [31:0] addr);
        bus.inst_addr = addr;
        bus.inst_req  = 1'b1;
        exp_inst.push_back(ref_mem[addr[9:2]]);
    endtask

    task automatic issue_data(input logic we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] w;
        w = ref_mem[addr[9:2]];
        if (we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[addr[9:2]] = w;
        end
        bus.data_we    = we;
        bus.data_sel   = sel;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
        bus.data_req   = 1'b1;
        exp_data.push_back(w);
    endtask

    task automatic wait_inst_ack(input bit keep);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.inst_ack && n < 100);
        check("inst_ack_seen", 32'(bus.inst_ack), 32'd1);
        tick();
        if (!keep) bus.inst_req = 1'b0;
    endtask

    task automatic wait_data_ack(input bit keep);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.data_ack && n < 100);
        check("data_ack_seen", 32'(bus.data_ack), 32'd1);
        tick();
        if (!keep) bus.data_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string order_exp;
        int    ack_before;
        int    n;
        int    t_prev;

        rst = 1'b0;
        mem_load = 1'b1;
        bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_sel = '0;
        bus.data_addr = '0; bus.data_wdata = '0;
        bus0.inst_req = 1'b0; bus0.inst_addr = '0;
        bus0.data_req = 1'b0; bus0.data_we = 1'b0; bus0.data_sel = '0;
        bus0.data_addr = '0; bus0.data_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        t_prev = 0;
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;

        // Reset with both requests held: everything reads zero.
        issue_fetch(32'h0000_0040);
        issue_data(1'b0, 4'hF, 32'h0000_0044, 32'h0);
        @(negedge clk);
        check("rst_ctrl", 32'({bus.inst_ack, bus.data_ack, bus.mem_ce, bus.mem_we, bus.stall_req}), 32'd0);
        check("rst_mem_sel", 32'(bus.mem_sel), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_inst_rdata", bus.inst_rdata, 32'd0);
        check("rst_data_rdata", bus.data_rdata, 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rel_ce_first_cycle", 32'(bus.mem_ce), 32'd0);
        @(negedge clk);
        check("rel_ce_second_cycle", 32'(bus.mem_ce), 32'd1);
        check("rel_data_first", bus.mem_addr, 32'h0000_0044);
        fork
            wait_data_ack(1'b0);
            wait_inst_ack(1'b0);
        join
        repeat (2) tick();

        // Single fetch with per-cycle timing.
        issue_fetch(32'h0000_0010);
        @(negedge clk);
        check("f_stall_n", 32'(bus.stall_req), 32'd1);
        check("f_ce_n", 32'(bus.mem_ce), 32'd0);
        @(negedge clk);
        check("f_ce_n1", 32'(bus.mem_ce), 32'd1);
        check("f_cmd_n1", 32'({bus.mem_we, bus.mem_sel}), 32'h0F);
        check("f_addr_n1", bus.mem_addr, 32'h0000_0010);
        check("f_stall_n1", 32'(bus.stall_req), 32'd1);
        @(negedge clk);
        check("f_ce_n2", 32'(bus.mem_ce), 32'd1);
        check("f_stall_n2", 32'(bus.stall_req), 32'd1);
        @(negedge clk);
        check("f_ack_n3", 32'(bus.inst_ack), 32'd1);
        check("f_rdata_n3", bus.inst_rdata, 32'h3401_1100);
        check("f_ce_n3", 32'(bus.mem_ce), 32'd0);
        check("f_stall_n3", 32'(bus.stall_req), 32'd0);
        tick();
        bus.inst_req = 1'b0;
        repeat (2) tick();

        // Store then load on the data port.
        ack_before = data_ack_cnt;
        issue_data(1'b1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        check("st_we_sel", 32'({bus.mem_we, bus.mem_sel}), 32'h13);
        check("st_addr", bus.mem_addr, 32'h0000_0020);
        check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        wait_data_ack(1'b0);
        repeat (3) tick();
        check("st_single_ack", 32'(data_ack_cnt - ack_before), 32'd1);
        issue_data(1'b0, 4'hF, 32'h0000_0020, 32'h0);
        wait_data_ack(1'b0);
        check("ld_low_half", 32'(bus.data_rdata[15:0]), 32'h0000_BEEF);
        repeat (2) tick();

        // Reset in the first ACCESS cycle abandons the access.
        ack_before = data_ack_cnt;
        issue_data(1'b0, 4'hF, 32'h0000_0020, 32'h0);
        tick();
        check("mid_ce_before_rst", 32'(bus.mem_ce), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_ce_in_rst", 32'(bus.mem_ce), 32'd0);
        check("mid_ack_in_rst", 32'(bus.data_ack), 32'd0);
        check("mid_state_idle", 32'(dut.state_q), 32'(IDLE));
        check("mid_starve_zero", 32'(dut.starve_cnt_q), 32'd0);
        repeat (2) tick();
        check("mid_no_ack", 32'(data_ack_cnt - ack_before), 32'd0);
        rst = 1'b1;
        wait_data_ack(1'b0);
        repeat (2) tick();
        check("mid_restart_ack", 32'(data_ack_cnt - ack_before), 32'd1);

        // Continuous contention: three data grants, then fetch is forced in.
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    issue_data(1'b0, 4'hF, 32'h0000_0100 + 32'(4 * k), 32'h0);
                    wait_data_ack(k < 5);
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    issue_fetch(32'h0000_0080 + 32'(4 * k));
                    wait_inst_ack(k < 1);
                end
            end
        join
        order_exp = "DDDIDDDI";
        check("order_len", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < grant_log.size()) check($sformatf("order_%0d", k), 32'(grant_log[k]), 32'(order_exp[k]));
        repeat (2) tick();

        // WAIT_CYCLES=0 instance: ack two cycles after request, then every three.
        for (int k = 0; k < 5; k++) begin
            bus0.inst_addr = 32'h0000_0010 + 32'(4 * k);
            bus0.inst_req  = 1'b1;
            exp_inst0.push_back(ref_mem[4 + k]);
            n = 0;
            do begin @(negedge clk); n++; end while (!bus0.inst_ack && n < 50);
            check("w0_ack_seen", 32'(bus0.inst_ack), 32'd1);
            if (k == 0) check("w0_first_latency", 32'(n), 32'd3);
            else        check("w0_ack_spacing", 32'(cyc - t_prev), 32'd3);
            t_prev = cyc;
            tick();
        end
        bus0.inst_req = 1'b0;
        repeat (4) tick();

        check("sb_drained", 32'(exp_inst.size() + exp_data.size() + exp_inst0.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sopc_mem_arbiter.md
Name: sopc_mem_arbiter

Overview:
- Shares one single-port synchronous memory (combined inst/data RAM) between the CPU instruction-fetch port and the CPU load/store port in the minimal SOPC.
- Data port has fixed priority, with a starvation guard for fetch.
- Inserts a configurable number of wait states and drives a stall request back to the CPU pipeline controller while any access is outstanding.

Parameters:
- WAIT_CYCLES, 1, extra memory cycles per access (range 0..7); mem_ce is held for WAIT_CYCLES+1 cycles.
- STARVE_LIMIT, 3, consecutive data grants made while fetch was pending before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held until inst_ack
- inst_addr  in  32  fetch byte address; stable while inst_req
- inst_rdata  out  32  fetch data; valid when inst_ack
- inst_ack  out  1  one-cycle completion pulse
- data_req  in  1  load/store request; held until data_ack
- data_we  in  1  1 = store
- data_sel  in  4  byte enables
- data_addr  in  32  byte address
- data_wdata  in  32  store data
- data_rdata  out  32  load data; valid when data_ack
- data_ack  out  1  one-cycle completion pulse
- mem_ce  out  1  memory chip enable
- mem_we  out  1  memory write enable
- mem_sel  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid in the last mem_ce cycle
- stall_req  out  1  to pipeline control: high while any request is pending and unacked

Behaviour:
- Reset: clk and rst only. rst low asynchronously forces:
  - state = IDLE
  - starvation counter = 0, wait counter = 0
  - all outputs 0
- A reset mid-access abandons the access; no ack is produced.
- FSM states:
  - IDLE: arbitrate.
    - Grant fetch if inst_req and (!data_req or starve_cnt == STARVE_LIMIT).
    - Else grant data if data_req.
    - Registered grant → ACCESS next cycle, wait_cnt = 0.
  - ACCESS:
    - mem_ce = 1. mem_addr/mem_we/mem_sel/mem_wdata are taken from the granted port.
    - For a fetch grant: mem_we = 0, mem_sel = 4'hF.
    - wait_cnt increments each cycle. When wait_cnt == WAIT_CYCLES, mem_rdata is registered into the granted port's rdata register → RESP.
  - RESP:
    - Granted port's ack = 1 for exactly this cycle; rdata is valid.
    - mem_ce = 0.
    - Always → IDLE.
- Latency: request visible in IDLE at cycle N → mem_ce high N+1 .. N+1+WAIT_CYCLES → ack at N+2+WAIT_CYCLES. WAIT_CYCLES=1 gives ack at N+3. Throughput is one access per WAIT_CYCLES+3 cycles.
- Stores: data_rdata is still updated with mem_rdata. Its value is don't-care, but the bench checks that it is deterministic.
- rdata registers hold their value until the next ack on the same port.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant issued while inst_req = 1.
  - Clears to 0 on any fetch grant.
  - Unchanged on a data grant with inst_req = 0.
- Simultaneous requests in IDLE: data wins unless the counter is saturated.
- Requester protocol: req, addr and the other controls are held until ack. A requester sampling ack drops req in the same cycle, or keeps it high to issue a new request. IDLE samples req fresh, so a req still high after ack is a new access.
- The arbiter does not latch the request fields; the port controls mux through during ACCESS, and a requester changing them mid-access is a protocol violation (assertion in bench).
- stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack), combinational.
- Address: full 32-bit pass-through. Word alignment is the memory's concern.

Decomposition:
- Shared package (defines):
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - grant_t enum {GNT_INST, GNT_DATA}
  - constants for WAIT_CYCLES/STARVE_LIMIT defaults
  - reuse of the existing RstEnable/ChipEnable/WriteEnable macros
- One natural sub-module: sopc_arb_prio, a combinational grant decision from inst_req, data_req and starve_cnt. Keeping it separate lets the priority policy be tested standalone.
- FSM, counters and muxes stay in the top module.

Test Plan:
- Reset: rst low with both reqs high → every output 0. Release rst → first mem_ce appears 2 cycles after release, not before.
- Single fetch, WAIT_CYCLES=1: inst_req at N, addr 0x0000_0010, mem holds 0x3401_1100 → mem_ce high at N+1 and N+2, inst_ack at N+3 with inst_rdata 0x3401_1100, stall_req high N..N+2.
- Store then load on the data port:
  - Store data_we=1, sel 4'b0011, addr 0x20, wdata 0xDEAD_BEEF → mem_we=1, mem_sel=0011 during ACCESS, data_ack once.
  - Load 0x20 → data_rdata = 0x????_BEEF (low half matches).
- Contention: both reqs high continuously, STARVE_LIMIT=3 → grant order D,D,D,I,D,D,D,I. No port ever waits more than 4 accesses.
- Reset mid-ACCESS: rst low at N+1 of a data access → data_ack never pulses, state IDLE, starve_cnt 0. After release, the held request restarts and completes.
- WAIT_CYCLES=0 build: fetch ack at N+2. Back-to-back fetches with req held → acks every 3 cycles, never two in consecutive cycles.
